request_arbiter_4: RTL and testbench
====================================

# request_arbiter_4

Four-line request capture and round-robin arbiter that sits directly upstream of the 4-to-2 encoder. It synchronizes four asynchronous request lines and latches each rising edge as a sticky pending request. It then issues exactly one one-hot grant at a time, and that grant drives the encoder's 4-bit `w` input. A valid/ready handshake with the consumer retires each grant.

## Interface

- `SYNC_STAGES`, default 2: synchronizer depth per request line; legal values ≥ 2.
- `clk` input 1: single clock, rising-edge active.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_in` input 4: raw request levels, asynchronous to `clk`.
- `grant` output 4: registered one-hot grant, or 0 when idle; connects to encoder `w`.
- `grant_valid` output 1: registered; `grant` holds a live request.
- `grant_ready` input 1: consumer accepts `grant` in this cycle.
- `pending` output 4: registered sticky pending-request flags (status).

## Operation

- Each `req_in[i]` passes through a `SYNC_STAGES`-deep flop chain. The final stage `s[i]` is also registered as `s_d[i]`.
- Edge detect: `rise[i] = s[i] & ~s_d[i]`. Only rising edges count; a held-high level raises exactly one request.
- On a clock edge, `pending[i]` is set if `rise[i]` is true. It is cleared if a handshake (`grant_valid & grant_ready`) retires grant bit i. If both happen on the same edge, set wins and `pending[i]` stays 1.
- A 2-bit pointer `last` holds the index of the most recently retired grant. Search order starts at `last+1` and increments mod 4 (wrap 3→0).
- FSM states:
  - IDLE: `grant=0`, `grant_valid=0`. If `pending != 0` at an edge, load `grant` with the one-hot of the first pending index in search order and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `grant_valid=1`. `grant` is frozen and must not change while `grant_ready=0`, even if new pending bits appear. On an edge with `grant_ready=1`: clear the granted pending bit (unless set wins), set `last` to the granted index, clear `grant`, and go to IDLE.
- `grant` is always one-hot or zero, never multi-hot. `grant_valid` equals (state == OFFER).

## Timing

- Reset (asynchronous, on `reset_n` low):
  - all synchronizer flops, `s_d`, `pending` and `grant` go to 0;
  - `grant_valid` goes to 0;
  - state goes to IDLE;
  - `last` goes to 3, so index 0 has first priority.
  - Reset takes effect immediately, mid-OFFER included; the in-flight grant is dropped without a handshake.
- Latency from request to grant: take E0 as the edge that first samples `req_in[i]=1` with no other requests active.
  - `pending[i]` is 1 after edge E0+`SYNC_STAGES`.
  - `grant_valid`=1 after edge E0+`SYNC_STAGES`+1, which is E0+3 at the default depth.
- Handshake: the transfer occurs on a rising edge where `grant_valid=1` and `grant_ready=1`. `grant_ready` while idle is ignored.
- Throughput: at most one grant per 2 cycles. Every handshake is followed by one IDLE cycle before the next grant.
- `grant_valid` drops in the cycle after the handshake edge.
- Requests must stay low at least `SYNC_STAGES`+1 cycles between pulses to register as separate edges. Narrower pulses may be missed or merged; this is accepted.

## Test plan

- Reset: hold `reset_n`=0 with `req_in`=4'hF → `grant`=0, `grant_valid`=0, `pending`=0. Release reset, `grant_ready`=1 → grants come out in the order 4'b0001, 4'b0010, 4'b0100, 4'b1000.
- Single request latency: `req_in`=4'b0100 sampled at edge E0 → `pending`=4'b0100 after E0+2, `grant`=4'b0100 with `grant_valid`=1 after E0+3. `req_in` held high → no second grant.
- Round-robin wrap: retire index 1 so `last`=1, then raise edges on bits 0 and 2 together → `grant` is 4'b0100 first, then 4'b0001.
- Backpressure: grant 4'b0001 with `grant_ready`=0 for 5 cycles while bit 3 rises → `grant` stays 4'b0001 and `pending`=4'b1001. Assert `grant_ready` → after one IDLE cycle, `grant` is 4'b1000.
- Set-wins collision: a new rising edge on bit 2 lands on the same edge as the handshake retiring grant 4'b0100 → `pending[2]` stays 1 and 4'b0100 is granted again after the IDLE cycle.
- Reset mid-OFFER: assert `reset_n`=0 asynchronously while `grant_valid`=1 → `grant`, `grant_valid` and `pending` go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/request_arbiter_4.sv
// request_arbiter_4: synchronizes four async request lines, latches rising edges as sticky
// pending flags and offers one round-robin one-hot grant at a time over valid/ready.
module request_arbiter_4 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req_in,
   output logic [3:0] grant,
   output logic       grant_valid,
   input  logic       grant_ready,
   output logic [3:0] pending
);
   typedef enum logic {IDLE, OFFER} state_t;
   state_t r_state, w_state_nx;
   logic [SYNC_STAGES-1:0][3:0] r_sync;
   logic [3:0] r_s_d, r_grant, r_pending, w_rise, w_grant_nx, w_pending_nx;
   logic [1:0] r_last, w_last_nx, w_idx, w_gidx;
   logic       w_hs;

   assign w_rise       = r_sync[SYNC_STAGES-1] & ~r_s_d;
   assign w_hs         = (r_state == OFFER) & grant_ready;
   assign w_gidx       = {r_grant[3] | r_grant[2], r_grant[3] | r_grant[1]};
   // a new rising edge on the retiring bit keeps it pending
   assign w_pending_nx = (r_pending & ~(w_hs ? r_grant : 4'b0)) | w_rise;
   assign grant        = r_grant;
   assign grant_valid  = (r_state == OFFER);
   assign pending      = r_pending;

   // scan from farthest to nearest so the first pending index after last wins
   always_comb begin
      w_idx = r_last + 2'd1;
      for (int k = 3; k >= 0; k--)
         if (r_pending[r_last + 2'(k + 1)]) w_idx = r_last + 2'(k + 1);
   end

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_last_nx  = r_last;
      if (r_state == IDLE && |r_pending) begin
         w_state_nx = OFFER;
         w_grant_nx = 4'b0001 << w_idx;
      end else if (w_hs) begin
         w_state_nx = IDLE;
         w_grant_nx = 4'b0;
         w_last_nx  = w_gidx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync    <= '0;
         r_s_d     <= 4'b0;
         r_pending <= 4'b0;
         r_grant   <= 4'b0;
         r_last    <= 2'd3;
         r_state   <= IDLE;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], req_in};
         r_s_d     <= r_sync[SYNC_STAGES-1];
         r_pending <= w_pending_nx;
         r_grant   <= w_grant_nx;
         r_last    <= w_last_nx;
         r_state   <= w_state_nx;
      end
   end
endmodule

// File: tb/tb_request_arbiter_4.sv
// tb_request_arbiter_4: directed stimulus against an index/modulo reference model of the arbiter.
module tb_request_arbiter_4;
   localparam int S = 2;
   logic       clk, reset_n, grant_ready, grant_valid;
   logic [3:0] req_in, grant, pending;
   int         n_checks = 0;
   int         n_errors = 0;

   request_arbiter_4 #(.SYNC_STAGES(S)) dut (
      .clk(clk), .reset_n(reset_n), .req_in(req_in), .grant(grant),
      .grant_valid(grant_valid), .grant_ready(grant_ready), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: sample history, pending flags, pointer and offered index
   logic [3:0] m_hist [0:S];
   logic [3:0] m_pend, m_rise, m_exp_grant;
   int         m_last, m_g, m_sel;
   logic       m_off, m_hs;

   always_comb begin
      m_rise = m_hist[S-1] & ~m_hist[S];
      m_hs   = m_off && grant_ready;
      m_sel  = -1;
      for (int k = 4; k >= 1; k--)
         if (m_pend[(m_last + k) % 4]) m_sel = (m_last + k) % 4;
      m_exp_grant = m_off ? 4'(1 << m_g) : 4'b0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k <= S; k++) m_hist[k] <= 4'b0;
         m_pend <= 4'b0;
         m_last <= 3;
         m_off  <= 1'b0;
         m_g    <= 0;
      end else begin
         for (int i = 0; i < 4; i++)
            m_pend[i] <= m_rise[i] | (m_pend[i] & !(m_hs && m_g == i));
         if (m_hs) begin
            m_last <= m_g;
            m_off  <= 1'b0;
         end else if (!m_off && m_sel >= 0) begin
            m_g   <= m_sel;
            m_off <= 1'b1;
         end
         m_hist[0] <= req_in;
         for (int k = 1; k <= S; k++) m_hist[k] <= m_hist[k-1];
      end
   end

   always @(posedge clk) begin
      #1;
      chk("cyc_grant", grant, m_exp_grant);
      chk("cyc_valid", {3'b0, grant_valid}, {3'b0, m_off});
      chk("cyc_pending", pending, m_pend);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(input logic [3:0] exp, input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!grant_valid && n < 20);
      if (!grant_valid) chk({name, "_timeout"}, 4'b0, 4'b1);
      else chk(name, grant, exp);
   endtask

   initial begin
      reset_n = 1'b0; req_in = 4'hF; grant_ready = 1'b0;
      repeat (3) tick();
      chk("rst_grant", grant, 4'b0);
      chk("rst_valid", {3'b0, grant_valid}, 4'b0);
      chk("rst_pending", pending, 4'b0);
      reset_n = 1'b1; grant_ready = 1'b1;
      wait_grant(4'b0001, "rr_g0");
      wait_grant(4'b0010, "rr_g1");
      wait_grant(4'b0100, "rr_g2");
      wait_grant(4'b1000, "rr_g3");
      req_in = 4'b0;
      repeat (5) tick();
      chk("drain_pending", pending, 4'b0);
      chk("drain_valid", {3'b0, grant_valid}, 4'b0);
      // single request latency
      req_in = 4'b0100;
      repeat (3) tick();
      chk("lat_pending", pending, 4'b0100);
      chk("lat_valid_lo", {3'b0, grant_valid}, 4'b0);
      tick();
      chk("lat_grant", grant, 4'b0100);
      chk("lat_valid_hi", {3'b0, grant_valid}, 4'b1);
      tick();
      repeat (10) begin
         tick();
         chk("held_no_regrant", {3'b0, grant_valid}, 4'b0);
      end
      req_in = 4'b0;
      repeat (5) tick();
      // round-robin wrap after last=1
      req_in = 4'b0010;
      wait_grant(4'b0010, "wrap_setup");
      req_in = 4'b0;
      repeat (5) tick();
      req_in = 4'b0101;
      wait_grant(4'b0100, "wrap_first");
      wait_grant(4'b0001, "wrap_second");
      req_in = 4'b0;
      repeat (5) tick();
      // backpressure
      grant_ready = 1'b0;
      req_in = 4'b0001;
      wait_grant(4'b0001, "bp_grant");
      req_in = 4'b1001;
      repeat (5) begin
         tick();
         chk("bp_frozen", grant, 4'b0001);
      end
      chk("bp_pending", pending, 4'b1001);
      grant_ready = 1'b1;
      tick();
      chk("bp_idle_valid", {3'b0, grant_valid}, 4'b0);
      chk("bp_idle_grant", grant, 4'b0);
      tick();
      chk("bp_next", grant, 4'b1000);
      tick();
      req_in = 4'b0;
      repeat (5) tick();
      // set wins over handshake clear
      grant_ready = 1'b0;
      req_in = 4'b0100;
      wait_grant(4'b0100, "sw_grant");
      req_in = 4'b0;
      repeat (4) tick();
      req_in = 4'b0100;
      tick();
      tick();
      grant_ready = 1'b1;
      tick();
      chk("sw_pending", pending, 4'b0100);
      chk("sw_idle", {3'b0, grant_valid}, 4'b0);
      tick();
      chk("sw_regrant", grant, 4'b0100);
      chk("sw_regrant_valid", {3'b0, grant_valid}, 4'b1);
      tick();
      chk("sw_cleared", pending, 4'b0);
      req_in = 4'b0; grant_ready = 1'b0;
      repeat (4) tick();
      // asynchronous reset mid-offer
      req_in = 4'b1001;
      wait_grant(4'b1000, "ar_grant");
      chk("ar_pending_pre", pending, 4'b1001);
      #3 reset_n = 1'b0;
      #1;
      chk("ar_grant", grant, 4'b0);
      chk("ar_valid", {3'b0, grant_valid}, 4'b0);
      chk("ar_pending", pending, 4'b0);
      repeat (2) tick();
      req_in = 4'b0;
      reset_n = 1'b1;
      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end
endmodule
